// File: rtl/mcu_pkg.sv
// Shared MCU definitions: stage codes seen by the control unit, default bus widths.
package mcu_pkg;

  localparam int MCU_ADDR_W  = 8;
  localparam int MCU_INSTR_W = 12;

  typedef enum logic [1:0] {
    STG_LOAD    = 2'b00,
    STG_FETCH   = 2'b01,
    STG_DECODE  = 2'b10,
    STG_EXECUTE = 2'b11
  } stage_e;

endpackage

// File: rtl/stage_sequencer.sv
// Stage sequencer: program load over valid/ready, then FETCH/DECODE/EXECUTE with run/pause/step.
// Outputs registered, one load word per cycle; load_ready is high only in LOAD (no stall within LOAD).
module stage_sequencer
  import mcu_pkg::*;
#(
  parameter int ADDR_W  = MCU_ADDR_W,
  parameter int INSTR_W = MCU_INSTR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               reload,
  input  logic               run_en,
  input  logic               step_req,
  output logic [1:0]         stage,
  output logic [ADDR_W-1:0]  load_addr,
  output logic [INSTR_W-1:0] load_instr,
  output logic               pc_clr,
  output logic               running,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_PAUSE
  } state_e;

  state_e              state_q, state_d;
  logic                step_q, step_d;
  logic [ADDR_W-1:0]   idx_q;
  logic                accept;
  logic                last_word;
  stage_e              stage_d;

  assign accept    = (state_q == S_LOAD) && load_valid;
  assign last_word = load_last || (idx_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept && last_word)
          state_d = run_en ? S_FETCH : S_PAUSE;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // a stepped instruction always returns to pause, whatever run_en says
        state_d = (step_q || !run_en) ? S_PAUSE : S_FETCH;
        step_d  = 1'b0;
      end
      S_PAUSE: begin
        if (reload) begin
          state_d = S_LOAD;
        end else if (step_req) begin
          state_d = S_DECODE;
          step_d  = 1'b1;
        end else if (run_en) begin
          state_d = S_DECODE;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    stage_d = STG_FETCH;
    unique case (state_d)
      S_LOAD:   stage_d = STG_LOAD;
      S_DECODE: stage_d = STG_DECODE;
      S_EXEC:   stage_d = STG_EXECUTE;
      default:  stage_d = STG_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      step_q      <= 1'b0;
      idx_q       <= '0;
      load_addr   <= '0;
      load_instr  <= '0;
      pc_clr      <= 1'b0;
      running     <= 1'b0;
      stage       <= STG_LOAD;
      load_ready  <= 1'b1;
      instr_count <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      stage      <= stage_d;
      load_ready <= (state_d == S_LOAD);
      running    <= (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
      pc_clr     <= accept && last_word;
      if (accept) begin
        load_addr  <= idx_q;
        load_instr <= load_data;
        idx_q      <= last_word ? '0 : idx_q + ADDR_W'(1);
      end
      if (state_q == S_EXEC)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: default instance plus a small ADDR_W=2/CNT_W=4 instance.
module tb_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-width instance
  logic        rst = 1'b1, lv = 1'b0, ll = 1'b0, reload = 1'b0, run_en = 1'b0, step_req = 1'b0;
  logic [11:0] ld = '0;
  logic        load_ready, pc_clr, running;
  logic [1:0]  stage;
  logic [7:0]  load_addr;
  logic [11:0] load_instr;
  logic [15:0] instr_count;

  // small instance for fill auto-exit and counter wrap
  logic        rst2 = 1'b1, lv2 = 1'b0, ll2 = 1'b0, reload2 = 1'b0, run2 = 1'b0, step2 = 1'b0;
  logic [11:0] ld2 = '0;
  logic        load_ready2, pc_clr2, running2;
  logic [1:0]  stage2;
  logic [1:0]  load_addr2;
  logic [11:0] load_instr2;
  logic [3:0]  instr_count2;

  stage_sequencer dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_last(ll),
    .load_ready(load_ready), .reload(reload), .run_en(run_en), .step_req(step_req),
    .stage(stage), .load_addr(load_addr), .load_instr(load_instr), .pc_clr(pc_clr),
    .running(running), .instr_count(instr_count)
  );

  stage_sequencer #(.ADDR_W(2), .INSTR_W(12), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .load_valid(lv2), .load_data(ld2), .load_last(ll2),
    .load_ready(load_ready2), .reload(reload2), .run_en(run2), .step_req(step2),
    .stage(stage2), .load_addr(load_addr2), .load_instr(load_instr2), .pc_clr(pc_clr2),
    .running(running2), .instr_count(instr_count2)
  );

  typedef struct {
    bit          sel;
    logic [1:0]  stage;
    logic        running;
    logic        pc_clr;
    logic [15:0] cnt;
    bit          ld_chk;
    logic [7:0]  addr;
    logic [11:0] instr;
    logic        ready;
    int          seq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   seq = 0;

  function automatic exp_t ex(bit sel, logic [1:0] st, bit run, bit pc, int cnt);
    exp_t e;
    e.sel = sel; e.stage = st; e.running = run; e.pc_clr = pc; e.cnt = 16'(cnt);
    e.ld_chk = 1'b0; e.addr = '0; e.instr = '0; e.ready = (st == 2'b00); e.seq = 0;
    return e;
  endfunction

  function automatic exp_t exl(bit sel, logic [1:0] st, bit run, bit pc, int cnt,
                               int addr, logic [11:0] instr);
    exp_t e;
    e = ex(sel, st, run, pc, cnt);
    e.ld_chk = 1'b1; e.addr = 8'(addr); e.instr = instr;
    return e;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle#%0d actual=%0h required=%0h", nm, idx, act, req);
    end
  endtask

  // expected state after this rising edge goes to the scoreboard; inputs then change 1ns later
  task automatic tick(input exp_t e);
    @(posedge clk);
    e.seq = seq;
    seq++;
    exp_q.push_back(e);
    #1;
  endtask

  // monitor: outputs are valid every cycle, compared at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (!e.sel) begin
        chk("stage",   e.seq, 32'(stage),       32'(e.stage));
        chk("running", e.seq, 32'(running),     32'(e.running));
        chk("pc_clr",  e.seq, 32'(pc_clr),      32'(e.pc_clr));
        chk("count",   e.seq, 32'(instr_count), 32'(e.cnt));
        chk("ready",   e.seq, 32'(load_ready),  32'(e.ready));
        if (e.ld_chk) begin
          chk("load_addr",  e.seq, 32'(load_addr),  32'(e.addr));
          chk("load_instr", e.seq, 32'(load_instr), 32'(e.instr));
        end
      end else begin
        chk("stage2",   e.seq, 32'(stage2),       32'(e.stage));
        chk("running2", e.seq, 32'(running2),     32'(e.running));
        chk("pc_clr2",  e.seq, 32'(pc_clr2),      32'(e.pc_clr));
        chk("count2",   e.seq, 32'(instr_count2), 32'(e.cnt));
        chk("ready2",   e.seq, 32'(load_ready2),  32'(e.ready));
        if (e.ld_chk) begin
          chk("load_addr2",  e.seq, 32'(load_addr2),  32'(e.addr));
          chk("load_instr2", e.seq, 32'(load_instr2), 32'(e.instr));
        end
      end
    end
  end

  initial begin
    // reset
    tick(exl(0, 2'b00, 0, 0, 0, 0, 12'h000));
    tick(exl(0, 2'b00, 0, 0, 0, 0, 12'h000));

    // load three words, last on the third
    rst = 1'b0; run_en = 1'b1; lv = 1'b1; ld = 12'h801;
    tick(exl(0, 2'b00, 0, 0, 0, 0, 12'h801));
    ld = 12'h402;
    tick(exl(0, 2'b00, 0, 0, 0, 1, 12'h402));
    ld = 12'h303; ll = 1'b1;
    tick(exl(0, 2'b01, 1, 1, 0, 2, 12'h303));
    lv = 1'b0; ll = 1'b0;

    // free-run: D,E,F x3
    tick(ex(0, 2'b10, 1, 0, 0)); tick(ex(0, 2'b11, 1, 0, 0)); tick(ex(0, 2'b01, 1, 0, 1));
    tick(ex(0, 2'b10, 1, 0, 1)); tick(ex(0, 2'b11, 1, 0, 1)); tick(ex(0, 2'b01, 1, 0, 2));
    tick(ex(0, 2'b10, 1, 0, 2)); tick(ex(0, 2'b11, 1, 0, 2)); tick(ex(0, 2'b01, 1, 0, 3));

    // step_req during free-run is ignored; run_en drops during DECODE
    step_req = 1'b1;
    tick(ex(0, 2'b10, 1, 0, 3));
    step_req = 1'b0; run_en = 1'b0;
    tick(ex(0, 2'b11, 1, 0, 3));
    tick(ex(0, 2'b01, 0, 0, 4));
    tick(ex(0, 2'b01, 0, 0, 4)); tick(ex(0, 2'b01, 0, 0, 4)); tick(ex(0, 2'b01, 0, 0, 4));

    // single step
    step_req = 1'b1;
    tick(ex(0, 2'b10, 1, 0, 4));
    step_req = 1'b0;
    tick(ex(0, 2'b11, 1, 0, 4));
    tick(ex(0, 2'b01, 0, 0, 5));
    tick(ex(0, 2'b01, 0, 0, 5)); tick(ex(0, 2'b01, 0, 0, 5));

    // resume from pause, then pause again
    run_en = 1'b1;
    tick(ex(0, 2'b10, 1, 0, 5)); tick(ex(0, 2'b11, 1, 0, 5)); tick(ex(0, 2'b01, 1, 0, 6));
    run_en = 1'b0;
    tick(ex(0, 2'b10, 1, 0, 6)); tick(ex(0, 2'b11, 1, 0, 6)); tick(ex(0, 2'b01, 0, 0, 7));

    // reload beats step; next word lands at address 0
    reload = 1'b1; step_req = 1'b1;
    tick(exl(0, 2'b00, 0, 0, 7, 2, 12'h303));
    reload = 1'b0; step_req = 1'b0; lv = 1'b1; ld = 12'h555; ll = 1'b1;
    tick(exl(0, 2'b01, 0, 1, 7, 0, 12'h555));
    lv = 1'b0; ll = 1'b0;
    tick(exl(0, 2'b01, 0, 0, 7, 0, 12'h555));

    // reset mid-load
    reload = 1'b1;
    tick(exl(0, 2'b00, 0, 0, 7, 0, 12'h555));
    reload = 1'b0; lv = 1'b1; ld = 12'h111;
    tick(exl(0, 2'b00, 0, 0, 7, 0, 12'h111));
    ld = 12'h222;
    tick(exl(0, 2'b00, 0, 0, 7, 1, 12'h222));
    rst = 1'b1;
    tick(exl(0, 2'b00, 0, 0, 0, 0, 12'h000));
    rst = 1'b0; ld = 12'h333; ll = 1'b1; run_en = 1'b1;
    tick(exl(0, 2'b01, 1, 1, 0, 0, 12'h333));

    // reload outside pause is ignored
    lv = 1'b0; ll = 1'b0; reload = 1'b1;
    tick(ex(0, 2'b10, 1, 0, 0));
    tick(ex(0, 2'b11, 1, 0, 0));
    reload = 1'b0;
    tick(ex(0, 2'b01, 1, 0, 1));

    // small instance: fill to the top address without load_last
    rst2 = 1'b0; run2 = 1'b1; lv2 = 1'b1; ld2 = 12'hA01;
    tick(exl(1, 2'b00, 0, 0, 0, 0, 12'hA01));
    ld2 = 12'hA02;
    tick(exl(1, 2'b00, 0, 0, 0, 1, 12'hA02));
    ld2 = 12'hA03;
    tick(exl(1, 2'b00, 0, 0, 0, 2, 12'hA03));
    ld2 = 12'hA04;
    tick(exl(1, 2'b01, 1, 1, 0, 3, 12'hA04));
    lv2 = 1'b0;

    // 16 instructions: the 4-bit counter wraps back to 0
    for (int i = 1; i <= 48; i++) begin
      logic [1:0] st;
      st = (i % 3 == 1) ? 2'b10 : (i % 3 == 2) ? 2'b11 : 2'b01;
      tick(ex(1, st, 1, 0, (i / 3) % 16));
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drain", seq, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
